tdc_hitskip_ctrl: RTL and testbench



---
 rtl/tdc_hitskip_ctrl.sv | 130 +++++++++++++
 tb/tb_tdc_hitskip_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tdc_hitskip_ctrl.sv
// Per-channel hit-skip controller: forwards one hit in every (ratio+1) per channel and counts drops.
// Optional HITSKIP_CLR_ON_READ_EN: a readout clears the selected channel's drop counter.

module tdc_hitskip_lane #(
  parameter int SKIPW = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit,
  input  logic             en,
  input  logic             skip_act,
  input  logic             load,
  input  logic             clr,
  input  logic             rd_clr,
  input  logic [SKIPW-1:0] ratio,
  output logic             fwd_q,
  output logic [CNTW-1:0]  cnt
);
  logic [SKIPW-1:0] phase;
  logic             take, fwd, drop;

  assign take = hit && en;
  assign fwd  = take && (!skip_act || (phase == '0));
  assign drop = take && skip_act && (phase != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q <= 1'b0;
      phase <= '0;
      cnt   <= '0;
    end else begin
      fwd_q <= fwd;
      // A reload always lands the phase at 0, even if this cycle's hit was evaluated
      if (load)
        phase <= '0;
      else if (take && skip_act)
        phase <= (phase == '0) ? ratio : phase - 1'b1;
      if (clr)
        cnt <= '0;
      else if (rd_clr)
        cnt <= drop ? CNTW'(1) : '0;
      else if (drop && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end
endmodule

module tdc_hitskip_ctrl #(
  parameter int NCH   = 4,
  parameter int SKIPW = 4,
  parameter int CNTW  = 16,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   hit_in,
  input  logic [NCH-1:0]   chan_en,
  input  logic             enable_hitskip,
  input  logic [SKIPW-1:0] skip_ratio,
  input  logic             ratio_load,
  input  logic             cnt_clr,
  input  logic             rd_req,
  input  logic [SELW-1:0]  rd_sel,
  output logic [NCH-1:0]   hit_out,
  output logic             hitskip,
  output logic             rd_valid,
  output logic [CNTW-1:0]  rd_data
);
  logic [SKIPW-1:0]          ratio_q;
  logic                      en_q;
  logic                      load, skip_act;
  logic [NCH-1:0][CNTW-1:0]  cnt;
  logic [CNTW-1:0]           rd_mux;

  // Rising edge of the enable re-latches the ratio just like an explicit load
  assign load     = ratio_load || (enable_hitskip && !en_q);
  assign skip_act = en_q && (ratio_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ratio_q <= '0;
      en_q    <= 1'b0;
      hitskip <= 1'b0;
    end else begin
      en_q    <= enable_hitskip;
      hitskip <= skip_act;
      if (load) ratio_q <= skip_ratio;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    logic rd_clr;
`ifdef HITSKIP_CLR_ON_READ_EN
    assign rd_clr = rd_req && (rd_sel == SELW'(i));
`else
    assign rd_clr = 1'b0;
`endif
    tdc_hitskip_lane #(.SKIPW(SKIPW), .CNTW(CNTW)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .hit      (hit_in[i]),
      .en       (chan_en[i]),
      .skip_act (skip_act),
      .load     (load),
      .clr      (cnt_clr),
      .rd_clr   (rd_clr),
      .ratio    (ratio_q),
      .fwd_q    (hit_out[i]),
      .cnt      (cnt[i])
    );
  end

  // Out-of-range selects fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NCH; i++)
      if (rd_sel == SELW'(i)) rd_mux = cnt[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux;
    end
  end
endmodule

// File: tb/tb_tdc_hitskip_ctrl.sv
// Directed bench for tdc_hitskip_ctrl: a 4-channel/16-bit instance and a 5-channel/4-bit instance.
module tb_tdc_hitskip_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  int          ncmp = 0;
  int          nerr = 0;

  logic [3:0]  hit_in, chan_en, hit_out, skip_ratio;
  logic        enable_hitskip, ratio_load, cnt_clr, rd_req, hitskip, rd_valid;
  logic [1:0]  rd_sel;
  logic [15:0] rd_data;

  logic [4:0]  hit2, chan_en2, hit_out2;
  logic [3:0]  ratio2, rd_data2;
  logic        enable2, ratio_load2, cnt_clr2, rd_req2, hitskip2, rd_valid2;
  logic [2:0]  rd_sel2;

  always #5 clk = ~clk;

  tdc_hitskip_ctrl #(.NCH(4), .SKIPW(4), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .hit_in(hit_in), .chan_en(chan_en),
    .enable_hitskip(enable_hitskip), .skip_ratio(skip_ratio), .ratio_load(ratio_load),
    .cnt_clr(cnt_clr), .rd_req(rd_req), .rd_sel(rd_sel), .hit_out(hit_out),
    .hitskip(hitskip), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  tdc_hitskip_ctrl #(.NCH(5), .SKIPW(4), .CNTW(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .hit_in(hit2), .chan_en(chan_en2),
    .enable_hitskip(enable2), .skip_ratio(ratio2), .ratio_load(ratio_load2),
    .cnt_clr(cnt_clr2), .rd_req(rd_req2), .rd_sel(rd_sel2), .hit_out(hit_out2),
    .hitskip(hitskip2), .rd_valid(rd_valid2), .rd_data(rd_data2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One hit pattern, check the forwarded pulse, then an idle cycle to check it is 1 cycle wide
  task automatic hit(input logic [3:0] v, input logic [3:0] exp, input string tag);
    hit_in = v;
    tick();
    check(tag, {28'd0, hit_out}, {28'd0, exp});
    hit_in = '0;
    tick();
    check({tag, "_idle"}, {28'd0, hit_out}, 32'd0);
  endtask

  task automatic rd(input logic [1:0] sel, input logic [15:0] exp, input string tag);
    rd_req = 1'b1;
    rd_sel = sel;
    tick();
    rd_req = 1'b0;
    check({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
    check(tag, {16'd0, rd_data}, {16'd0, exp});
    tick();
    check({tag, "_vld_off"}, {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] exp_rd2, exp_ch0;
`ifdef HITSKIP_CLR_ON_READ_EN
    exp_rd2 = 16'd0;
    exp_ch0 = 16'd2;
`else
    exp_rd2 = 16'd6;
    exp_ch0 = 16'd8;
`endif
    rst_n = 1'b0;
    hit_in = '0; chan_en = '0; skip_ratio = '0; enable_hitskip = 1'b0;
    ratio_load = 1'b0; cnt_clr = 1'b0; rd_req = 1'b0; rd_sel = '0;
    hit2 = '0; chan_en2 = '0; ratio2 = '0; enable2 = 1'b0;
    ratio_load2 = 1'b0; cnt_clr2 = 1'b0; rd_req2 = 1'b0; rd_sel2 = '0;
    #3;
    check("rst_hit_out", {28'd0, hit_out}, 32'd0);
    check("rst_hitskip", {31'd0, hitskip}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    #4 rst_n = 1'b1;
    tick();

    // ratio 3: hits 1 and 5 forwarded, 6 dropped
    chan_en = 4'hF; skip_ratio = 4'd3; enable_hitskip = 1'b1;
    tick();
    check("hs_latch", {31'd0, hitskip}, 32'd0);
    tick();
    check("hs_on", {31'd0, hitskip}, 32'd1);
    hit(4'b0001, 4'b0001, "r3_h1");
    hit(4'b0001, 4'b0000, "r3_h2");
    hit(4'b0001, 4'b0000, "r3_h3");
    hit(4'b0001, 4'b0000, "r3_h4");
    hit(4'b0001, 4'b0001, "r3_h5");
    hit(4'b0001, 4'b0000, "r3_h6");
    hit(4'b0001, 4'b0000, "r3_h7");
    hit(4'b0001, 4'b0000, "r3_h8");
    rd(2'd0, 16'd6, "rd_ch0_a");
    rd(2'd0, exp_rd2, "rd_ch0_b");

    // skipping off: everything forwarded
    enable_hitskip = 1'b0;
    tick(); tick();
    check("hs_off", {31'd0, hitskip}, 32'd0);
    for (int k = 0; k < 5; k++) hit(4'b0100, 4'b0100, "en0_ch2");
    rd(2'd2, 16'd0, "rd_ch2_en0");
    skip_ratio = 4'd0; enable_hitskip = 1'b1;
    tick(); tick();
    check("hs_r0", {31'd0, hitskip}, 32'd0);
    for (int k = 0; k < 3; k++) hit(4'b0100, 4'b0100, "r0_ch2");
    rd(2'd2, 16'd0, "rd_ch2_r0");

    // ratio 1 via explicit load; disabled channel, then independent phases
    skip_ratio = 4'd1; ratio_load = 1'b1;
    tick();
    ratio_load = 1'b0;
    tick();
    check("hs_r1", {31'd0, hitskip}, 32'd1);
    chan_en = 4'b1101;
    for (int k = 0; k < 4; k++) hit(4'b0010, 4'b0000, "dis_ch1");
    rd(2'd1, 16'd0, "rd_ch1_dis");
    chan_en = 4'hF;
    hit(4'b1111, 4'b1111, "all_1");
    hit(4'b0001, 4'b0000, "ch0_only");
    hit(4'b1111, 4'b0001, "all_2");
    hit(4'b1111, 4'b1110, "all_3");

    // load with a same-cycle hit: old phase drops it, phase still restarts at 0
    skip_ratio = 4'd2; ratio_load = 1'b1;
    hit_in = 4'b0010;
    tick();
    ratio_load = 1'b0; hit_in = '0;
    check("load_hit_drop", {28'd0, hit_out}, 32'd0);
    tick();
    hit(4'b0010, 4'b0010, "post_load_fwd");
    hit(4'b0010, 4'b0000, "post_load_drop");
    rd(2'd0, exp_ch0, "rd_ch0_c");
    rd(2'd1, 16'd3, "rd_ch1_c");

    // clear beats a same-cycle drop
    cnt_clr = 1'b1; hit_in = 4'b0010;
    tick();
    cnt_clr = 1'b0; hit_in = '0;
    check("clr_drop_out", {28'd0, hit_out}, 32'd0);
    tick();
    rd(2'd1, 16'd0, "rd_ch1_clr");
    rd(2'd0, 16'd0, "rd_ch0_clr");

    // narrow counters saturate; out-of-range selects read 0; back-to-back reads
    chan_en2 = 5'h1F; ratio2 = 4'd15; enable2 = 1'b1;
    tick(); tick();
    check("hs2_on", {31'd0, hitskip2}, 32'd1);
    hit2 = 5'b00001;
    for (int k = 0; k < 300; k++) tick();
    hit2 = '0;
    rd_req2 = 1'b1; rd_sel2 = 3'd5;
    tick();
    check("rd2_sel5_vld", {31'd0, rd_valid2}, 32'd1);
    check("rd2_sel5", {28'd0, rd_data2}, 32'd0);
    rd_sel2 = 3'd0;
    tick();
    check("rd2_sat_vld", {31'd0, rd_valid2}, 32'd1);
    check("rd2_sat", {28'd0, rd_data2}, 32'd15);
    rd_sel2 = 3'd7;
    tick();
    check("rd2_sel7", {28'd0, rd_data2}, 32'd0);
    rd_req2 = 1'b0;
    cnt_clr2 = 1'b1; hit2 = 5'b00001;
    tick();
    cnt_clr2 = 1'b0; hit2 = '0;
    check("clr2_drop_out", {27'd0, hit_out2}, 32'd0);
    rd_req2 = 1'b1; rd_sel2 = 3'd0;
    tick();
    rd_req2 = 1'b0;
    check("rd2_clr", {28'd0, rd_data2}, 32'd0);
    tick();

    // asynchronous reset mid-burst kills in-flight pulses
    hit_in = 4'hF; rd_req = 1'b1; rd_sel = 2'd3;
    tick();
    check("pre_rst_vld", {31'd0, rd_valid}, 32'd1);
    check("pre_rst_hs", {31'd0, hitskip}, 32'd1);
    #2 rst_n = 1'b0;
    hit_in = '0; rd_req = 1'b0;
    #1;
    check("mid_rst_hit_out", {28'd0, hit_out}, 32'd0);
    check("mid_rst_hitskip", {31'd0, hitskip}, 32'd0);
    check("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("mid_rst_rd_data", {16'd0, rd_data}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    hit(4'b1000, 4'b1000, "post_rst_fwd");
    hit(4'b1000, 4'b0000, "post_rst_drop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
